upd_iq_noise_packer: RTL
========================

// Module: upd_iq_noise_packer
// PURPOSE
//  Upstream feeder of the slow-PHY-to-LLR sender. Packs per-RE IQ samples 4-per-word and noise samples 8-per-word
//  into 128-bit words, and writes them to the IQ and noise FIFOs that the sender drains (FIFO wdata ports below).
//  One user per start pulse; partial last words are padded and flushed, then o_user_done pulses.
// PARAMETERS
//  SAMPLE_W  16  I, Q and noise sample width; the consumer requires 16
//  IQ_LANES   4  REs per IQ word; RE k: I at [32k+15:32k], Q at [32k+31:32k+16]
//  NS_LANES   8  noise samples per noise word; sample n at [16n+15:16n]
// PORTS
//  i_core_clk              in   1    single clock, all logic rising-edge
//  i_rx_rstn               in   1    asynchronous active-low reset
//  i_user_start            in   1    1-cycle pulse, latches the user config
//  i_cur_user_re_amounts   in   16   N = REs in this user
//  i_user_iq_noise_rate    in   16   R = REs per noise sample (0 treated as 1)
//  i_iq_valid              in   1    IQ sample valid
//  i_iq_data_i/_q          in   16   IQ sample
//  o_iq_ready              out  1    IQ sample accepted when valid&ready
//  i_noise_valid           in   1    noise sample valid
//  i_noise_data            in   16   noise sample
//  o_noise_ready           out  1    noise accepted when valid&ready
//  i_iq_fifo_full          in   1    IQ FIFO almost-full (>=1 free entry remaining)
//  o_iq_fifo_wr_en         out  1    IQ FIFO write strobe
//  o_iq_fifo_wdata         out  128  packed IQ word (drives IQ_Data_SUM side)
//  i_noise_fifo_full       in   1    noise FIFO almost-full
//  o_noise_fifo_wr_en      out  1    noise FIFO write strobe
//  o_noise_fifo_wdata      out  128  packed noise word (drives Noise_Data_SUM side)
//  o_busy                  out  1    high from IDLE exit to DONE
//  o_user_done             out  1    1-cycle pulse, user complete
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lane/sample counters 0, wdata 0. Async assert; reset mid-user drops partial words.
//  FSM: IDLE -(i_user_start)-> CALC -> RUN -> FLUSH -> DONE -> IDLE. i_user_start outside IDLE is ignored.
//  CALC: latch N,R; NS = ceil(N/R) by repeated subtraction of R, one per cycle (ceil(N/R)+1 cycles max).
//    N==0: CALC -> DONE directly, no FIFO writes.
//  RUN: o_iq_ready = iq_left!=0 & !i_iq_fifo_full; o_noise_ready = ns_left!=0 & !i_noise_fifo_full.
//    Ready outputs are combinational from registered state; IQ and noise streams are independent.
//    Each accept writes the current lane and increments the lane counter (wrap 3->0 / 7->0).
//    Accept into the last lane: wr_en pulses the NEXT cycle with the full word; the lane register clears.
//    RUN -> FLUSH when iq_left==0 and ns_left==0 (all accepts done).
//  FLUSH: each stream with lane!=0 writes one padded word; the two flushes may write in the same cycle.
//    A stream waits while its full is high. Unused lanes are 0. FLUSH -> DONE when no partial words remain.
//  DONE: o_user_done=1 for one cycle; it follows the last wr_en by >=1 cycle.
//  Widths: counters 16-bit; N up to 65535. NS computed without overflow (remainder saturates at 0).
//  wr_en is never asserted while the matching full was high in the accepting cycle.
//  Total IQ words = ceil(N/4); noise words = ceil(NS/8).
// CONFIGURATION
//  UPD_PACK_PAD_REPLICATE_EN defined: flush pads unused lanes with a copy of the last accepted lane of that stream.
//    The noise lane copies the 16-bit noise sample; the IQ lane copies the full 32-bit I/Q pair.
//  Not defined: unused lanes are zero. Word counts and timing are identical either way.
// TESTING
//  N=8,R=2, streams always valid, no full -> 2 IQ words (RE0..3, RE4..7), 1 noise word lanes0-3 data, lanes4-7 0, done.
//  N=6,R=4 -> NS=2; IQ word2 lanes 2,3 = 0 (replicas of RE5 with macro); noise word lanes 2-7 = 0.
//  N=16,R=2, i_iq_fifo_full high 10 cycles mid-word -> o_iq_ready low throughout, no writes lost or duplicated, 4 words.
//  N=0 start -> o_busy ~2 cycles, zero wr_en, one o_user_done.
//  i_user_start pulsed during RUN -> ignored, config unchanged; rstn low mid-RUN -> outputs 0, IDLE, next user clean.
//  N=4,R=1, last IQ and 4th noise accepted same cycle -> IQ word written next cycle, noise partial flushed, done after.

Source files
------------

// File: rtl/upd_iq_noise_packer.sv
// Packs per-RE IQ samples (4 per word) and noise samples (8 per word) into 128-bit FIFO words for one user per start pulse.
// Optional UPD_PACK_PAD_REPLICATE_EN: flush pads unused lanes with the last accepted lane instead of zero.
module upd_iq_noise_packer #(
    parameter int SAMPLE_W = 16,
    parameter int IQ_LANES = 4,
    parameter int NS_LANES = 8
) (
    input  logic                             i_core_clk,
    input  logic                             i_rx_rstn,
    input  logic                             i_user_start,
    input  logic [15:0]                      i_cur_user_re_amounts,
    input  logic [15:0]                      i_user_iq_noise_rate,
    input  logic                             i_iq_valid,
    input  logic [SAMPLE_W-1:0]              i_iq_data_i,
    input  logic [SAMPLE_W-1:0]              i_iq_data_q,
    output logic                             o_iq_ready,
    input  logic                             i_noise_valid,
    input  logic [SAMPLE_W-1:0]              i_noise_data,
    output logic                             o_noise_ready,
    input  logic                             i_iq_fifo_full,
    output logic                             o_iq_fifo_wr_en,
    output logic [IQ_LANES*2*SAMPLE_W-1:0]   o_iq_fifo_wdata,
    input  logic                             i_noise_fifo_full,
    output logic                             o_noise_fifo_wr_en,
    output logic [NS_LANES*SAMPLE_W-1:0]     o_noise_fifo_wdata,
    output logic                             o_busy,
    output logic                             o_user_done
);

    localparam int IQ_W  = 2 * SAMPLE_W;
    localparam int IQ_LW = $clog2(IQ_LANES);
    localparam int NS_LW = $clog2(NS_LANES);
    localparam logic [IQ_LW-1:0] IQ_LAST = IQ_LW'(IQ_LANES - 1);
    localparam logic [NS_LW-1:0] NS_LAST = NS_LW'(NS_LANES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_RUN, ST_FLUSH, ST_DONE} state_t;

    state_t state, state_nxt;

    logic [15:0] rate;
    logic [15:0] calc_rem;
    logic [15:0] iq_left;
    logic [15:0] ns_left;
    logic [IQ_LW-1:0] iq_lane;
    logic [NS_LW-1:0] ns_lane;
    logic [IQ_LANES-1:0][IQ_W-1:0]     iq_buf, iq_full_word, iq_pad_word;
    logic [NS_LANES-1:0][SAMPLE_W-1:0] ns_buf, ns_full_word, ns_pad_word;
    logic iq_acc, ns_acc;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_user_start) state_nxt = ST_CALC;
            ST_CALC:  if (calc_rem == 16'd0) state_nxt = (iq_left == 16'd0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (iq_left == 16'd0 && ns_left == 16'd0) state_nxt = ST_FLUSH;
            ST_FLUSH: if (iq_lane == '0 && ns_lane == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_iq_ready    = (state == ST_RUN) && (iq_left != 16'd0) && !i_iq_fifo_full;
        o_noise_ready = (state == ST_RUN) && (ns_left != 16'd0) && !i_noise_fifo_full;
        o_busy        = (state != ST_IDLE);
        o_user_done   = (state == ST_DONE);
    end

    assign iq_acc = o_iq_ready & i_iq_valid;
    assign ns_acc = o_noise_ready & i_noise_valid;

    // Lanes above the write pointer are always zero in the buffers, so zero padding is the buffer itself.
    always_comb begin
        iq_full_word          = iq_buf;
        iq_full_word[iq_lane] = {i_iq_data_q, i_iq_data_i};
        ns_full_word          = ns_buf;
        ns_full_word[ns_lane] = i_noise_data;
        iq_pad_word           = iq_buf;
        ns_pad_word           = ns_buf;
`ifdef UPD_PACK_PAD_REPLICATE_EN
        for (int k = 0; k < IQ_LANES; k++)
            if (k >= int'(iq_lane)) iq_pad_word[k] = iq_buf[iq_lane - 1'b1];
        for (int k = 0; k < NS_LANES; k++)
            if (k >= int'(ns_lane)) ns_pad_word[k] = ns_buf[ns_lane - 1'b1];
`endif
    end

    // ns_left counts up during CALC (one per subtraction of R), then down as noise samples are accepted.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            rate               <= '0;
            calc_rem           <= '0;
            iq_left            <= '0;
            ns_left            <= '0;
            iq_lane            <= '0;
            ns_lane            <= '0;
            iq_buf             <= '0;
            ns_buf             <= '0;
            o_iq_fifo_wr_en    <= 1'b0;
            o_iq_fifo_wdata    <= '0;
            o_noise_fifo_wr_en <= 1'b0;
            o_noise_fifo_wdata <= '0;
        end else begin
            o_iq_fifo_wr_en    <= 1'b0;
            o_noise_fifo_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_user_start) begin
                        rate     <= (i_user_iq_noise_rate == 16'd0) ? 16'd1 : i_user_iq_noise_rate;
                        calc_rem <= i_cur_user_re_amounts;
                        iq_left  <= i_cur_user_re_amounts;
                        ns_left  <= '0;
                        iq_lane  <= '0;
                        ns_lane  <= '0;
                        iq_buf   <= '0;
                        ns_buf   <= '0;
                    end
                end
                ST_CALC: begin
                    if (calc_rem != 16'd0) begin
                        calc_rem <= (calc_rem > rate) ? calc_rem - rate : 16'd0;
                        ns_left  <= ns_left + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (iq_acc) begin
                        iq_left <= iq_left - 16'd1;
                        if (iq_lane == IQ_LAST) begin
                            o_iq_fifo_wdata <= iq_full_word;
                            o_iq_fifo_wr_en <= 1'b1;
                            iq_lane         <= '0;
                            iq_buf          <= '0;
                        end else begin
                            iq_buf  <= iq_full_word;
                            iq_lane <= iq_lane + 1'b1;
                        end
                    end
                    if (ns_acc) begin
                        ns_left <= ns_left - 16'd1;
                        if (ns_lane == NS_LAST) begin
                            o_noise_fifo_wdata <= ns_full_word;
                            o_noise_fifo_wr_en <= 1'b1;
                            ns_lane            <= '0;
                            ns_buf             <= '0;
                        end else begin
                            ns_buf  <= ns_full_word;
                            ns_lane <= ns_lane + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (iq_lane != '0 && !i_iq_fifo_full) begin
                        o_iq_fifo_wdata <= iq_pad_word;
                        o_iq_fifo_wr_en <= 1'b1;
                        iq_lane         <= '0;
                        iq_buf          <= '0;
                    end
                    if (ns_lane != '0 && !i_noise_fifo_full) begin
                        o_noise_fifo_wdata <= ns_pad_word;
                        o_noise_fifo_wr_en <= 1'b1;
                        ns_lane            <= '0;
                        ns_buf             <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
